// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable data memory controller.
// Accepts one load/store at a time, supports word/half/byte accesses with
// sign or zero extension, and reports illegal requests through resp_err.
// Optional feature macro: DM_MISALIGN_EN. When defined, accesses that cross a
// word boundary complete in two memory cycles. When undefined, any access that
// is not naturally aligned is rejected.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; req_ready=1
// ACC0  | first-word access (read, or write of first-word bytes)
// ACC1  | second-word access of a request that spans two words
// RESP  | resp_valid pulse; response registers already loaded
module dmem_ctrl #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_type,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] mem [DEPTH];

    logic             we_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       type_q;
    logic [31:0]      lo_q;

    logic [1:0]       off;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic [IDX_W-1:0] widx;
    logic [2:0]       acc_size;
    logic [3:0]       size_mask;
    logic             bad_type;
    logic             reject;
    logic             spans;
    logic [7:0]       lane_mask;
    logic [63:0]      wdata64;
    logic [3:0]       lane_sel;
    logic [31:0]      wword;
    logic             wr_en;
    logic [31:0]      rd_word;
    logic [63:0]      data64;
    logic [31:0]      rd_shift;
    logic [31:0]      load_ext;
    logic             resp_load;
    logic             unused_addr;

    // Address bits above the word index are don't-care.
    assign unused_addr = ^req_addr[31:IDX_W+2];

    assign off  = addr_q[1:0];
    assign idx0 = addr_q[IDX_W+1:2];
    assign idx1 = idx0 + IDX_W'(1);   // wraps to word 0 past the top of memory

    // Decode access size and decide whether the request is rejected or spans.
    always_comb begin
        acc_size  = 3'd1;
        size_mask = 4'b0001;
        bad_type  = 1'b0;
        case (type_q)
            3'b000:         begin acc_size = 3'd4; size_mask = 4'b1111; end
            3'b001, 3'b010: begin acc_size = 3'd2; size_mask = 4'b0011; end
            3'b011, 3'b100: begin acc_size = 3'd1; size_mask = 4'b0001; end
            default:        bad_type = 1'b1;
        endcase
`ifdef DM_MISALIGN_EN
        reject = bad_type;
        spans  = !bad_type && (({1'b0, off} + acc_size) > 3'd4);
`else
        reject = bad_type
               || ((acc_size == 3'd4) && (off != 2'd0))
               || ((acc_size == 3'd2) && off[0]);
        spans  = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ACC0;
            end
            ACC0:    state_nxt = spans ? ACC1 : RESP;
            ACC1:    state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request fields on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
        end else if (req_valid && req_ready) begin
            we_q    <= req_we;
            addr_q  <= req_addr[IDX_W+1:0];
            wdata_q <= req_wdata;
            type_q  <= req_type;
        end
    end

    // Store data and lanes laid out across the two candidate words.
    assign lane_mask = {4'b0000, size_mask} << off;
    assign wdata64   = {32'h0, wdata_q} << {off, 3'b000};
    assign widx      = (state == ACC1) ? idx1 : idx0;
    assign lane_sel  = (state == ACC1) ? lane_mask[7:4] : lane_mask[3:0];
    assign wword     = (state == ACC1) ? wdata64[63:32] : wdata64[31:0];
    assign wr_en     = we_q && !reject && ((state == ACC0) || (state == ACC1));

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_sel[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    // Load path: first word is held in lo_q while the second word is read.
    assign rd_word  = mem[widx];
    assign data64   = (state == ACC1) ? {rd_word, lo_q} : {32'h0, rd_word};
    assign rd_shift = 32'(data64 >> {off, 3'b000});

    // Extend the assembled bytes according to the access type.
    always_comb begin
        load_ext = 32'h0;
        case (type_q)
            3'b000:  load_ext = rd_shift;
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_ext = {16'h0, rd_shift[15:0]};
            3'b011:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_ext = {24'h0, rd_shift[7:0]};
            default: load_ext = 32'h0;
        endcase
    end

    assign resp_load = ((state == ACC0) && !spans) || (state == ACC1);

    // Response registers load on the edge entering RESP and hold until the next.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lo_q       <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == ACC0) lo_q <= rd_word;
            if (resp_load) begin
                resp_err   <= reject;
                resp_rdata <= (reject || we_q) ? 32'h0 : load_ext;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (default depth 4096).
module tb_dmem_ctrl;

    localparam int DEPTH = 4096;
    localparam logic [31:0] TOP_BYTE = 32'(4*DEPTH - 1);
    localparam logic [31:0] TOP_WORD = 32'(4*DEPTH - 4);

    localparam logic [2:0] T_W  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_HU = 3'b010;
    localparam logic [2:0] T_B  = 3'b011;
    localparam logic [2:0] T_BU = 3'b100;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    dmem_ctrl #(.DEPTH(DEPTH), .IDX_W(12)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_type   (req_type),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request from IDLE; returns response fields and latency in cycles
    // counting the accept cycle as cycle 0.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] typ, output logic [31:0] rdata,
                        output logic err, output int latency);
        bit seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_type  = typ;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        latency   = 1;
        seen      = 1'b0;
        rdata     = 32'hx;
        err       = 1'bx;
        while (!seen && latency < 10) begin
            @(negedge clk);
            if (resp_valid) begin
                seen  = 1'b1;
                rdata = resp_rdata;
                err   = resp_err;
            end else begin
                @(posedge clk);
                latency++;
            end
        end
        chk("resp_timeout", 32'(seen), 32'd1);
        @(posedge clk);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] d, input logic [2:0] typ);
        logic [31:0] r;
        logic        e;
        int          l;
        xfer(1'b1, addr, d, typ, r, e, l);
    endtask

    task automatic ld_chk(input string tag, input logic [31:0] addr, input logic [2:0] typ,
                          input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        int          l;
        xfer(1'b0, addr, 32'h0, typ, r, e, l);
        chk(tag, r, exp);
        chk({tag, "_err"}, 32'(e), 32'd0);
    endtask

    initial begin
        int acc;
        int rsp;

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_type  = '0;
        #23;
        chk("rst_ready",  32'(req_ready),  32'd1);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_rdata",  resp_rdata,      32'h0);
        chk("rst_err",    32'(resp_err),   32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Aligned word store then load.
        xfer(1'b1, 32'h10, 32'h11223344, T_W, rd, er, lat);
        chk("st_w_err", 32'(er), 32'd0);
        chk("st_w_rdata", rd, 32'h0);
        chk("st_w_lat", 32'(lat), 32'd2);
        xfer(1'b0, 32'h10, 32'h0, T_W, rd, er, lat);
        chk("ld_w", rd, 32'h11223344);
        chk("ld_w_err", 32'(er), 32'd0);
        chk("ld_w_lat", 32'(lat), 32'd2);
        repeat (3) @(negedge clk);
        chk("rdata_hold", resp_rdata, 32'h11223344);

        // Sub-word extension.
        st(32'h20, 32'h000080F0, T_W);
        ld_chk("ld_b",  32'h20, T_B,  32'hFFFFFFF0);
        ld_chk("ld_bu", 32'h20, T_BU, 32'h000000F0);
        ld_chk("ld_h",  32'h20, T_H,  32'hFFFF80F0);
        ld_chk("ld_hu", 32'h20, T_HU, 32'h000080F0);

        // Sub-word stores only touch covered bytes; 100/010 store as byte/half.
        st(32'h13, 32'hFFFFFF5A, T_BU);
        ld_chk("st_b_merge", 32'h10, T_W, 32'h5A223344);
        st(32'h12, 32'h12347788, T_HU);
        ld_chk("st_h_merge", 32'h10, T_W, 32'h77883344);
        ld_chk("ld_h_pos",   32'h12, T_H,  32'h00007788);
        ld_chk("ld_b_off1",  32'h11, T_B,  32'h00000033);
        ld_chk("ld_bu_off3", 32'h13, T_BU, 32'h00000077);
        ld_chk("hi_addr_ign", 32'h80000010, T_W, 32'h77883344);

        // Illegal type: no write, error, zero data.
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 3'b111, rd, er, lat);
        chk("bad_st_err", 32'(er), 32'd1);
        chk("bad_st_rdata", rd, 32'h0);
        chk("bad_st_lat", 32'(lat), 32'd2);
        ld_chk("bad_st_nowr", 32'h10, T_W, 32'h77883344);
        xfer(1'b0, 32'h10, 32'h0, 3'b101, rd, er, lat);
        chk("bad_ld_err", 32'(er), 32'd1);
        chk("bad_ld_rdata", rd, 32'h0);

`ifdef DM_MISALIGN_EN
        // Spanning store/load.
        st(32'h0, 32'h0, T_W);
        st(32'h4, 32'h0, T_W);
        xfer(1'b1, 32'h03, 32'hAABBCCDD, T_W, rd, er, lat);
        chk("span_st_lat", 32'(lat), 32'd3);
        chk("span_st_err", 32'(er), 32'd0);
        ld_chk("span_w0", 32'h0, T_W, 32'hDD000000);
        ld_chk("span_w1", 32'h4, T_W, 32'h00AABBCC);
        xfer(1'b0, 32'h03, 32'h0, T_W, rd, er, lat);
        chk("span_ld", rd, 32'hAABBCCDD);
        chk("span_ld_lat", 32'(lat), 32'd3);

        // Wrap from the top word to word 0.
        st(TOP_WORD, 32'h0, T_W);
        st(TOP_BYTE, 32'h0000BEEF, T_H);
        ld_chk("wrap_top", TOP_WORD, T_W, 32'hEF000000);
        ld_chk("wrap_w0",  32'h0,    T_W, 32'hDD0000BE);
        ld_chk("wrap_ld_h", TOP_BYTE, T_H, 32'hFFFFBEEF);
`else
        // Misaligned accesses are rejected.
        xfer(1'b0, 32'h02, 32'h0, T_W, rd, er, lat);
        chk("mis_ld_err", 32'(er), 32'd1);
        chk("mis_ld_rdata", rd, 32'h0);
        chk("mis_ld_lat", 32'(lat), 32'd2);
        xfer(1'b1, 32'h21, 32'h00001234, T_H, rd, er, lat);
        chk("mis_st_err", 32'(er), 32'd1);
        ld_chk("mis_st_nowr", 32'h20, T_W, 32'h000080F0);
        ld_chk("al_h_off2",   32'h22, T_HU, 32'h00000000);
`endif

        // Reset while in ACC0 of a word store at an unaligned address.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h05;
        req_wdata = 32'h12345678;
        req_type  = T_W;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("busy_ready", 32'(req_ready), 32'd0);
        rstn = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_rvalid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        rsp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) rsp++;
        end
        chk("midrst_noresp", 32'(rsp), 32'd0);
        ld_chk("post_rst_ld", 32'h10, T_W, 32'h77883344);

        // req_valid held high: one response per accept, nothing queued.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h20;
        req_type  = T_W;
        acc = 0;
        rsp = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) acc++;
            if (resp_valid) rsp++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid) rsp++;
            @(negedge clk);
        end
        chk("hold_accepts", 32'(acc), 32'd4);
        chk("hold_resps", 32'(rsp), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning the number of 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter IDX_W, default 12, equal to log2(DEPTH) and giving the word-index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: the reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port req_type, input, 3 bits: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: load result, extended per req_type.
REQ-013 SHALL have port resp_err, output, 1 bit: the completed request was rejected; valid with resp_valid.

Function
REQ-014 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, capturing all request fields.
REQ-015 SHALL drive req_ready=1 only in state IDLE.
REQ-016 SHALL implement states IDLE, ACC0, ACC1 and RESP.
- IDLE -> ACC0 on accept.
- ACC0 -> ACC1 if the access spans two words, else ACC0 -> RESP.
- ACC1 -> RESP.
- RESP -> IDLE unconditionally.
REQ-017 SHALL treat an access as spanning two words when the byte offset plus the access size exceeds 4.
- Size is 4 for word, 2 for half, 1 for byte.
- Offset is addr[1:0].
REQ-018 SHALL use word index addr[IDX_W+1:2] and ignore addr[31:IDX_W+2].
- The second word of a spanning access is index+1 modulo DEPTH, so the last word wraps to word 0.
REQ-019 SHALL store little-endian: byte k of the data goes to byte address addr+k.
- Only the bytes covered by the access are modified; all other bytes are unchanged.
REQ-020 SHALL perform store writes as follows:
- Non-spanning: in ACC0.
- Spanning: first-word bytes in ACC0, second-word bytes in ACC1.
REQ-021 SHALL treat store type 010 as 001 and store type 100 as 011.
REQ-022 SHALL handle loads as follows:
- Assemble bytes addr..addr+size-1 little-endian.
- Sign-extend for 001 and 011.
- Zero-extend for 010 and 100.
- Pass the full word for 000.
REQ-023 SHALL treat req_type values 101, 110 and 111 as an error:
- no memory write;
- resp_err=1;
- resp_rdata=0.
REQ-024 SHALL assert resp_valid for exactly the RESP cycle.
- resp_rdata and resp_err hold their values until the next RESP.
- resp_rdata for a store equals 0.
REQ-025 SHALL give the following latency from accept edge to resp_valid high:
- 2 cycles for a non-spanning access;
- 3 cycles for a spanning access.
- Throughput is one request per 3 or 4 cycles.
REQ-026 SHALL ignore req_valid while not in IDLE; no request is queued.

Reset
REQ-027 SHALL, on rstn low, immediately force:
- state IDLE;
- req_ready=1;
- resp_valid=0;
- resp_rdata=0;
- resp_err=0.
REQ-028 SHALL abort an in-flight request when reset is asserted mid-operation.
- No response is issued for it.
- A half-completed spanning store leaves its first-word bytes written and its second-word bytes unwritten.
REQ-029 SHALL NOT clear memory contents on reset.

Configuration
REQ-030 SHALL support macro DM_MISALIGN_EN.
- When defined, spanning accesses behave per REQ-016 to REQ-020.
- When undefined, any access that is not naturally aligned is rejected: no write, resp_err=1, resp_rdata=0, latency 2 cycles, and state ACC1 is never entered.
- Naturally aligned means word offset 0, half offset 0 or 2, byte any offset.

Verification
REQ-031 SHALL cover an aligned word sequence: store word 0x11223344 at 0x10, then load word at 0x10 -> resp_rdata=0x11223344, resp_err=0, resp_valid 2 cycles after accept.
REQ-032 SHALL cover sub-word extension: word 0x000080F0 at 0x20, load byte at 0x20 -> 0xFFFFFFF0; load byte unsigned -> 0x000000F0; load half -> 0xFFFF80F0; load half unsigned -> 0x000080F0.
REQ-033 SHALL cover a spanning store with DM_MISALIGN_EN defined: words 0x0 and 0x4 cleared, store word 0xAABBCCDD at 0x03 -> word 0x0 = 0xDD000000 and word 0x4 = 0x00AABBCC; load word at 0x03 -> 0xAABBCCDD with latency 3.
REQ-034 SHALL cover wrap-around with DM_MISALIGN_EN defined: half 0xBEEF stored at byte 4*DEPTH-1 -> top word byte 3 = 0xEF and word 0 byte 0 = 0xBE.
REQ-035 SHALL cover the error paths: req_type 111 -> resp_err=1 and memory unchanged; with DM_MISALIGN_EN undefined, load word at 0x02 -> resp_err=1 and resp_rdata=0.
REQ-036 SHALL cover reset and busy behaviour: rstn pulsed low in ACC0 of a spanning store -> resp_valid never asserted and req_ready=1 immediately; req_valid held high while busy -> exactly one response per accept.
